// File: rtl/disaggregator.sv
// Parallel-to-serial stage: pops one FETCH_WIDTH*DATA_WIDTH wide word from an
// upstream FIFO and pushes its lanes, lane 0 first, one DATA_WIDTH word per
// cycle into a downstream FIFO.
//
// An active register holds the word being serialised, and a prefetch register
// holds the following word. Together they sustain one narrow word per cycle
// across wide-word boundaries.
//
// Ports:
//   clk             - single clock; all state changes on the rising edge
//   rst             - asynchronous, active-high reset
//   sender_data     - upstream FIFO head; lane i = [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]
//   sender_empty_n  - upstream head valid
//   sender_deq      - pop the upstream head this cycle (sender_data is sampled)
//   receiver_data   - current narrow word (lane idx of the active word)
//   receiver_full_n - downstream can accept
//   receiver_enq    - push receiver_data this cycle
//   idle            - no wide word held
module disaggregator #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned FETCH_WIDTH = 4,
  parameter int unsigned IDX_WIDTH   = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [FETCH_WIDTH*DATA_WIDTH-1:0] sender_data,
  input  logic                              sender_empty_n,
  output logic                              sender_deq,
  output logic [DATA_WIDTH-1:0]             receiver_data,
  input  logic                              receiver_full_n,
  output logic                              receiver_enq,
  output logic                              idle
);

  localparam int unsigned WideWidth = FETCH_WIDTH * DATA_WIDTH;
  localparam logic [IDX_WIDTH-1:0] LastIdx = IDX_WIDTH'(FETCH_WIDTH - 1);

  logic [WideWidth-1:0] active_q, active_d;
  logic                 active_valid_q, active_valid_d;
  logic [WideWidth-1:0] next_q, next_d;
  logic                 next_valid_q, next_valid_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;

  logic last;

  // Handshakes depend only on registered state and the FIFO status flags.
  // Reset gating keeps both strobes low while rst is high.
  always_comb begin
    receiver_enq = active_valid_q & receiver_full_n & ~rst;
    sender_deq   = sender_empty_n & ~next_valid_q & ~rst;
    last         = receiver_enq & (idx_q == LastIdx);
    idle         = ~active_valid_q & ~next_valid_q;
  end

  // Lane select from the active register. A compare-based loop keeps the
  // selection in range when FETCH_WIDTH is not a power of two.
  always_comb begin
    receiver_data = '0;
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      if (idx_q == IDX_WIDTH'(i)) begin
        receiver_data = active_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Lane counter: it advances on each push, wraps after the last lane, and
  // holds while downstream is full.
  always_comb begin
    idx_d = idx_q;
    if (last) begin
      idx_d = '0;
    end else if (receiver_enq) begin
      idx_d = idx_q + IDX_WIDTH'(1);
    end
  end

  // Word registers. sender_deq is gated by !next_valid_q, so a last lane and
  // a pop in the same cycle always find the prefetch slot empty. In that case
  // the popped word becomes active directly, with no bubble.
  always_comb begin
    active_d       = active_q;
    active_valid_d = active_valid_q;
    next_d         = next_q;
    next_valid_d   = next_valid_q;

    if (last) begin
      if (next_valid_q) begin
        active_d     = next_q;
        next_valid_d = 1'b0;
      end else if (sender_deq) begin
        active_d = sender_data;
      end else begin
        active_valid_d = 1'b0;
      end
    end else if (sender_deq) begin
      if (!active_valid_q) begin
        active_d       = sender_data;
        active_valid_d = 1'b1;
      end else begin
        next_d       = sender_data;
        next_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q       <= '0;
      active_valid_q <= 1'b0;
      next_q         <= '0;
      next_valid_q   <= 1'b0;
      idx_q          <= '0;
    end else begin
      active_q       <= active_d;
      active_valid_q <= active_valid_d;
      next_q         <= next_d;
      next_valid_q   <= next_valid_d;
      idx_q          <= idx_d;
    end
  end

`ifndef SYNTHESIS
  // The prefetch slot is only ever filled behind a valid active word.
  next_implies_active: assert property (
    @(posedge clk) disable iff (rst) next_valid_q |-> active_valid_q);

  no_deq_when_full: assert property (
    @(posedge clk) disable iff (rst) sender_deq |-> !next_valid_q);

  idx_in_range: assert property (
    @(posedge clk) disable iff (rst) idx_q <= LastIdx);
`endif

endmodule

// File: tb/tb_disaggregator.sv
module tb_disaggregator;

  localparam int unsigned DW = 16;
  localparam int unsigned FW = 4;
  localparam int unsigned WW = DW * FW;

  logic          clk = 1'b0;
  logic          rst;
  logic [WW-1:0] sender_data;
  logic          sender_empty_n;
  logic          sender_deq;
  logic [DW-1:0] receiver_data;
  logic          receiver_full_n;
  logic          receiver_enq;
  logic          idle;

  disaggregator #(
    .DATA_WIDTH (DW),
    .FETCH_WIDTH(FW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .sender_data    (sender_data),
    .sender_empty_n (sender_empty_n),
    .sender_deq     (sender_deq),
    .receiver_data  (receiver_data),
    .receiver_full_n(receiver_full_n),
    .receiver_enq   (receiver_enq),
    .idle           (idle)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: upstream words waiting, narrow words owed downstream,
  // and the number of wide words the block currently holds (capacity 2).
  logic [WW-1:0] up_q[$];
  logic [DW-1:0] exp_q[$];
  int held        = 0;
  int lanes_out   = 0;
  int up_pct      = 100;
  int full_pct    = 100;
  int dut_deq_cnt = 0;

  typedef struct {
    logic          empty_n;
    logic          full_n;
    logic [WW-1:0] data;
    logic          exp_deq;
    logic          exp_enq;
    logic [DW-1:0] exp_data;
    logic          exp_idle;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [WW-1:0] mk_word(int base);
    logic [WW-1:0] w;
    w = '0;
    for (int i = 0; i < int'(FW); i++) w[i*DW +: DW] = DW'(base + i);
    return w;
  endfunction

  function automatic vec_t mkv(logic e, logic f, logic [WW-1:0] d, logic xd, logic xe,
                               int xdata, logic xi);
    vec_t v;
    v.empty_n  = e;
    v.full_n   = f;
    v.data     = d;
    v.exp_deq  = xd;
    v.exp_enq  = xe;
    v.exp_data = DW'(xdata);
    v.exp_idle = xi;
    return v;
  endfunction

  task automatic chk(string name, logic [WW-1:0] act, logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_inputs();
    sender_empty_n  = (up_q.size() > 0) && (int'($urandom_range(99)) < up_pct);
    sender_data     = (up_q.size() > 0) ? up_q[0] : '0;
    receiver_full_n = (int'($urandom_range(99)) < full_pct);
  endtask

  // One cycle against the model: sample at the falling edge, update the model
  // from its own expectations, then drive new inputs just after the rising edge.
  task automatic run_cycle();
    logic          x_deq, x_enq;
    logic [WW-1:0] w;
    @(negedge clk);
    x_deq = sender_empty_n && (held < 2);
    x_enq = (held > 0) && receiver_full_n;
    chk("sender_deq", sender_deq, x_deq);
    chk("receiver_enq", receiver_enq, x_enq);
    chk("idle", idle, held == 0);
    if (sender_deq) dut_deq_cnt++;
    if (x_enq) begin
      chk("receiver_data", receiver_data, exp_q[0]);
      void'(exp_q.pop_front());
      lanes_out++;
      if (lanes_out == int'(FW)) begin
        lanes_out = 0;
        held--;
      end
    end
    if (x_deq) begin
      w = up_q.pop_front();
      for (int i = 0; i < int'(FW); i++) exp_q.push_back(w[i*DW +: DW]);
      held++;
    end
    @(posedge clk);
    #1;
    drive_inputs();
  endtask

  task automatic run_until_drained(int budget);
    int n;
    n = 0;
    while ((up_q.size() > 0 || held > 0) && n < budget) begin
      run_cycle();
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d cycles required < %0d", n, budget);
    end
    chk("idle_after_drain", idle, 1'b1);
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    sender_empty_n  = 1'b1;
    sender_data     = '1;
    receiver_full_n = 1'b1;
    up_q.delete();
    exp_q.delete();
    held      = 0;
    lanes_out = 0;
    @(negedge clk);
    chk("reset_enq", receiver_enq, 1'b0);
    chk("reset_deq", sender_deq, 1'b0);
    chk("reset_idle", idle, 1'b1);
    chk("reset_data", receiver_data, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive_inputs();
  endtask

  task automatic run_table();
    foreach (vecs[i]) begin
      sender_empty_n  = vecs[i].empty_n;
      sender_data     = vecs[i].data;
      receiver_full_n = vecs[i].full_n;
      @(negedge clk);
      chk($sformatf("vec%0d_deq", i), sender_deq, vecs[i].exp_deq);
      chk($sformatf("vec%0d_enq", i), receiver_enq, vecs[i].exp_enq);
      chk($sformatf("vec%0d_idle", i), idle, vecs[i].exp_idle);
      if (vecs[i].exp_enq) chk($sformatf("vec%0d_data", i), receiver_data, vecs[i].exp_data);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst             = 1'b1;
    sender_empty_n  = 1'b0;
    sender_data     = '0;
    receiver_full_n = 1'b0;
    do_reset();

    // Starvation, then a last-lane/deq coincidence with one stalled cycle.
    vecs.push_back(mkv(1, 1, mk_word(10), 1, 0, 0, 1));
    vecs.push_back(mkv(0, 1, '0, 0, 1, 10, 0));
    vecs.push_back(mkv(0, 1, '0, 0, 1, 11, 0));
    vecs.push_back(mkv(0, 1, '0, 0, 1, 12, 0));
    vecs.push_back(mkv(0, 1, '0, 0, 1, 13, 0));
    vecs.push_back(mkv(0, 1, '0, 0, 0, 0, 1));
    vecs.push_back(mkv(1, 1, mk_word(0), 1, 0, 0, 1));
    vecs.push_back(mkv(0, 1, '0, 0, 1, 0, 0));
    vecs.push_back(mkv(0, 1, '0, 0, 1, 1, 0));
    vecs.push_back(mkv(0, 0, '0, 0, 0, 0, 0));
    vecs.push_back(mkv(0, 1, '0, 0, 1, 2, 0));
    vecs.push_back(mkv(1, 1, mk_word(4), 1, 1, 3, 0));
    vecs.push_back(mkv(0, 1, '0, 0, 1, 4, 0));
    vecs.push_back(mkv(0, 1, '0, 0, 1, 5, 0));
    vecs.push_back(mkv(0, 1, '0, 0, 1, 6, 0));
    vecs.push_back(mkv(0, 1, '0, 0, 1, 7, 0));
    vecs.push_back(mkv(0, 1, '0, 0, 0, 0, 1));
    run_table();

    // Streaming, upstream always ready, downstream never full.
    full_pct = 100;
    up_pct   = 100;
    for (int k = 0; k < 8; k++) up_q.push_back(mk_word(4 * k));
    drive_inputs();
    run_until_drained(100);

    // Downstream backpressure.
    do_reset();
    full_pct = 50;
    up_pct   = 100;
    for (int k = 0; k < 32; k++) up_q.push_back(mk_word(4 * k));
    drive_inputs();
    run_until_drained(2000);

    // Random data with gaps on both sides.
    do_reset();
    full_pct = 70;
    up_pct   = 60;
    for (int k = 0; k < 24; k++) up_q.push_back({$urandom(), $urandom()});
    drive_inputs();
    run_until_drained(2000);

    // Full buffering: only two words may be taken while downstream is full.
    do_reset();
    full_pct = 0;
    up_pct   = 100;
    for (int k = 0; k < 3; k++) up_q.push_back(mk_word(100 + 4 * k));
    drive_inputs();
    dut_deq_cnt = 0;
    repeat (6) run_cycle();
    chk("deq_count_while_full", dut_deq_cnt, 2);
    full_pct = 100;
    drive_inputs();
    run_until_drained(100);

    // Reset after lane 1 of a word, with a second word prefetched.
    do_reset();
    full_pct = 100;
    up_pct   = 100;
    up_q.push_back(mk_word(40));
    up_q.push_back(mk_word(44));
    up_q.push_back(mk_word(48));
    drive_inputs();
    repeat (3) run_cycle();
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_enq", receiver_enq, 1'b0);
    chk("midrst_deq", sender_deq, 1'b0);
    chk("midrst_idle", idle, 1'b1);
    chk("midrst_data", receiver_data, '0);
    do_reset();
    up_q.push_back(mk_word(20));
    drive_inputs();
    run_until_drained(50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
